// File: rtl/led_pwm_pkg.sv
// Shared types and constants for the LED PWM driver.
// Optional build macro used by this block: LED_PWM_GAMMA_EN (see led_pwm_driver).
package led_pwm_pkg;

    // Default bit width of level, duty and period counter; period = 2^WIDTH cycles.
    localparam int unsigned WIDTH_DEFAULT = 8;

    // Controller states: idle (counter parked), running, and draining to a period boundary.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } state_e;

endpackage

// File: rtl/led_pwm_gamma.sv
// Combinational square-law brightness mapping: level = (val * val) >> WIDTH.
// Instantiated by led_pwm_driver only when LED_PWM_GAMMA_EN is defined.
module led_pwm_gamma
    import led_pwm_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] val,
    output logic [WIDTH-1:0] level
);

    logic [2*WIDTH-1:0] val_ext;
    logic [2*WIDTH-1:0] prod;

    // Full double-width product; keep the upper half.
    always_comb begin
        val_ext = {{WIDTH{1'b0}}, val};
        prod    = val_ext * val_ext;
        level   = prod[2*WIDTH-1:WIDTH];
    end

endmodule

// File: rtl/led_pwm_driver.sv
// LED PWM driver with double-buffered duty and drain-to-boundary shutdown.
// Build option: define LED_PWM_GAMMA_EN to square-map VAL on capture
// (captured = (VAL*VAL) >> WIDTH); otherwise VAL is captured unchanged.
// PWM and PERIOD_END are registered views of the slot processed in the previous cycle,
// so the PERIOD_END of the final drained period lands in the first IDLE cycle.
module led_pwm_driver
    import led_pwm_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] VAL,
    output logic             PWM,
    output logic             PERIOD_END,
    output logic             BUSY
);

    localparam logic [WIDTH-1:0] CntMax = '1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic             pwm_q, pwm_d;
    logic             pe_q, pe_d;
    logic [WIDTH-1:0] cap_val;
    logic             active;
    logic             wrap;

`ifdef LED_PWM_GAMMA_EN
    led_pwm_gamma #(
        .WIDTH (WIDTH)
    ) u_gamma (
        .val   (VAL),
        .level (cap_val)
    );
`else
    assign cap_val = VAL;
`endif

    assign active = (state_q == StRun) || (state_q == StDrain);
    assign wrap   = active && (cnt_q == CntMax);

    // Next-state: mode transitions, counter, shadow/active duty and registered outputs.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        duty_d   = duty_q;
        pwm_d    = 1'b0;
        pe_d     = 1'b0;

        if (LOAD) begin
            shadow_d = cap_val;
        end

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (EN) begin
                    state_d = StRun;
                    duty_d  = shadow_q;
                end
            end
            StRun: begin
                if (!EN) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (EN) begin
                    state_d = StRun;
                end else if (wrap) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (active) begin
            cnt_d = cnt_q + 1'b1;
            pwm_d = (cnt_q < duty_q);
            pe_d  = wrap;
            // Duty only changes at the boundary; a LOAD in the wrap cycle bypasses the shadow.
            if (wrap) begin
                duty_d = LOAD ? cap_val : shadow_q;
            end
        end
    end

    // State register with synchronous reset; reset discards a coincident LOAD.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            shadow_q <= '0;
            duty_q   <= '0;
            pwm_q    <= 1'b0;
            pe_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            duty_q   <= duty_d;
            pwm_q    <= pwm_d;
            pe_q     <= pe_d;
        end
    end

    assign PWM        = pwm_q;
    assign PERIOD_END = pe_q;
    assign BUSY       = (state_q != StIdle);

endmodule

// File: tb/tb_led_pwm_driver.sv
// Self-checking bench for led_pwm_driver: directed period-level scenarios plus a
// randomized phase, all checked against a behavioural model of the driver rules.
module tb_led_pwm_driver;

    localparam int W = 8;
    localparam int P = 1 << W;

    logic         CLK = 1'b0;
    logic         RST;
    logic         EN;
    logic         LOAD;
    logic [W-1:0] VAL;
    logic         PWM;
    logic         PERIOD_END;
    logic         BUSY;

    led_pwm_driver #(
        .WIDTH (W)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .EN         (EN),
        .LOAD       (LOAD),
        .VAL        (VAL),
        .PWM        (PWM),
        .PERIOD_END (PERIOD_END),
        .BUSY       (BUSY)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Level actually captured for a given VAL in this build.
    function automatic int g(input int v);
`ifdef LED_PWM_GAMMA_EN
        return (v * v) >> W;
`else
        return v;
`endif
    endfunction

    // Reference model: running flag, draining flag, current slot, duty and shadow level.
    bit m_busy  = 0;
    bit m_drain = 0;
    int m_slot  = 0;
    int m_duty  = 0;
    int m_shadow = 0;
    bit e_pwm   = 0;
    bit e_pe    = 0;

    // Period statistics gathered from the observed outputs.
    int hi_acc    = 0;
    int len_acc   = 0;
    int last_hi   = 0;
    int last_len  = 0;
    int pe_count  = 0;

    task automatic cycle();
        int cap;
        bit wrap;
        @(posedge CLK);
        cap = g(int'(VAL));
        if (RST) begin
            m_busy = 0; m_drain = 0; m_slot = 0; m_duty = 0; m_shadow = 0;
            e_pwm = 0; e_pe = 0;
        end else begin
            if (!m_busy) begin
                e_pwm = 0; e_pe = 0; m_slot = 0;
                if (EN) begin
                    m_busy = 1; m_drain = 0; m_duty = m_shadow;
                end
            end else begin
                wrap  = (m_slot == P - 1);
                e_pwm = (m_slot < m_duty);
                e_pe  = wrap;
                if (wrap) m_duty = LOAD ? cap : m_shadow;
                if (EN) m_drain = 0;
                else if (!m_drain) m_drain = 1;
                else if (wrap) m_busy = 0;
                m_slot = (m_slot + 1) % P;
            end
            if (LOAD) m_shadow = cap;
        end
        @(negedge CLK);
        check("pwm", int'(PWM), int'(e_pwm));
        check("period_end", int'(PERIOD_END), int'(e_pe));
        check("busy", int'(BUSY), int'(m_busy));
        if (RST) begin
            hi_acc = 0; len_acc = 0;
        end else begin
            len_acc++;
            if (PWM) hi_acc++;
            if (PERIOD_END) begin
                last_hi = hi_acc; last_len = len_acc;
                hi_acc = 0; len_acc = 0;
                pe_count++;
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic wait_pe();
        int start;
        start = pe_count;
        for (int i = 0; i < 3 * P && pe_count == start; i++) cycle();
        check("pe_timeout", int'(pe_count != start), 1);
    endtask

    task automatic load(input int v);
        VAL = W'(v); LOAD = 1'b1;
        run(1);
        LOAD = 1'b0;
    endtask

    initial begin
        int start;
        int drop;
        RST = 1'b1; EN = 1'b0; LOAD = 1'b0; VAL = '0;
        run(3);
        check("rst_pwm", int'(PWM), 0);
        check("rst_pe", int'(PERIOD_END), 0);
        check("rst_busy", int'(BUSY), 0);
        RST = 1'b0;
        run(2);

        // Basic duty
        load(64);
        EN = 1'b1;
        wait_pe();
        wait_pe();
        check("basic_hi", last_hi, g(64));
        check("basic_len", last_len, P);
        wait_pe();
        check("basic_hi2", last_hi, g(64));

        // Corner duties
        load(0);
        wait_pe();
        check("pre_zero_hi", last_hi, g(64));
        wait_pe();
        check("zero_hi", last_hi, 0);
        load(255);
        wait_pe();
        wait_pe();
        check("full_hi", last_hi, g(255));
        check("full_len", last_len, P);

        // Update timing: mid-period LOAD, then LOAD in the wrap cycle
        load(50);
        wait_pe();
        wait_pe();
        run(100);
        load(200);
        wait_pe();
        check("upd_cur_hi", last_hi, g(50));
        run(255);
        load(10);
        check("upd_next_hi", last_hi, g(200));
        wait_pe();
        check("wrap_load_hi", last_hi, g(10));

        // Drain from slot 30
        run(30);
        EN = 1'b0;
        start = pe_count;
        drop = 0;
        for (int i = 0; i < 2 * P && pe_count == start; i++) begin
            cycle();
            if (pe_count == start && !BUSY) drop++;
        end
        check("drain_end", pe_count - start, 1);
        check("drain_busy_gap", drop, 0);
        check("drain_len", last_len, P);
        check("drain_idle_busy", int'(BUSY), 0);
        run(1);
        check("idle_pwm", int'(PWM), 0);
        check("idle_pe", int'(PERIOD_END), 0);
        check("idle_busy", int'(BUSY), 0);

        // EN dropped and raised within one period
        load(100);
        EN = 1'b1;
        wait_pe();
        run(10);
        EN = 1'b0;
        run(10);
        EN = 1'b1;
        wait_pe();
        check("rerun_hi", last_hi, g(100));
        check("rerun_len", last_len, P);

        // Reset mid-run at slot 20 of a D=128 period
        load(128);
        wait_pe();
        run(20);
        RST = 1'b1;
        run(1);
        RST = 1'b0;
        check("midrst_pwm", int'(PWM), 0);
        check("midrst_pe", int'(PERIOD_END), 0);
        check("midrst_busy", int'(BUSY), 0);
        wait_pe();
        check("rst_restart_hi", last_hi, 0);
        load(30);
        wait_pe();
        check("rst_d0_hi", last_hi, 0);
        wait_pe();
        check("post_rst_hi", last_hi, g(30));

`ifdef LED_PWM_GAMMA_EN
        load(128);
        wait_pe();
        wait_pe();
        check("gamma_128_hi", last_hi, 64);
        load(16);
        wait_pe();
        wait_pe();
        check("gamma_16_hi", last_hi, 1);
`endif

        // Randomized phase
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) == 0) EN = ~EN;
            LOAD = ($urandom_range(0, 29) == 0);
            VAL  = W'($urandom);
            RST  = ($urandom_range(0, 1499) == 0);
            run(1);
        end
        LOAD = 1'b0;
        RST  = 1'b0;
        run(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
